nibble_packer: RTL and testbench

//  Write-side counterpart of the 128-bit nibble-select mux used in the A5/1 datapath.
//  - Accepts a stream of 4-bit nibbles over a valid/ready handshake.
//  - Writes nibble k into block[k*4+3:k*4], for k = 0..31. This is the same slot that the mux returns for index = k.
//  - Presents the assembled 128-bit block over a second valid/ready handshake.
//  - Sits between the nibble-serial keystream/plaintext source and the block-wide cipher/XOR stage.

---
 rtl/a51_pkg.sv | 16 +
 rtl/nibble_write_decoder.sv | 40 ++++
 rtl/nibble_packer.sv | 92 +++++++++
 tb/tb_nibble_packer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/a51_pkg.sv
// Shared constants and FSM encoding for the A5/1 nibble datapath
// (nibble-select mux on the read side, nibble_packer on the write side).
package a51_pkg;

  localparam int NIBBLE_W = 4;
  localparam int NIBBLES  = 32;
  localparam int IDX_W    = 5;
  localparam int BLOCK_W  = NIBBLE_W * NIBBLES;
  localparam int CNT_W    = IDX_W + 1;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } pk_state_e;

endpackage

// File: rtl/nibble_write_decoder.sv
// Write side of the nibble-select mux: 5->32 one-hot enable decode gated by
// accept, with one 4-bit register slice per enable. clear zeroes the block.
module nibble_write_decoder
  import a51_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                accept,
  input  logic                clear,
  input  logic [IDX_W-1:0]    idx,
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [BLOCK_W-1:0]  block
);

  logic [NIBBLES-1:0] wr_en;

  always_comb begin
    wr_en = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      wr_en[k] = accept && (idx == IDX_W'(k));
    end
  end

  for (genvar g = 0; g < NIBBLES; g++) begin : g_slice
    logic [NIBBLE_W-1:0] slice_q;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        slice_q <= '0;
      end else if (clear) begin
        slice_q <= '0;
      end else if (wr_en[g]) begin
        slice_q <= nibble;
      end
    end

    assign block[g*NIBBLE_W +: NIBBLE_W] = slice_q;
  end

endmodule

// File: rtl/nibble_packer.sv
// Packs a nibble stream LSB-first into 128-bit blocks. Optional partial-block
// flush is built only when NIBBLE_PACKER_FLUSH_EN is defined.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds data stable while valid && !ready, ready never depends on valid.
module nibble_packer
  import a51_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic [NIBBLE_W-1:0] in_nibble,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BLOCK_W-1:0]  block,
  output logic [CNT_W-1:0]    block_count,
  output logic                block_valid,
  input  logic                block_ready,
  output logic                fsm_state
`ifdef NIBBLE_PACKER_FLUSH_EN
  ,
  input  logic                flush
`endif
);

  pk_state_e            state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_W-1:0]     count_q;
  logic                 accept;
  logic                 consume;
  logic                 last;
  logic                 flush_req;

  assign accept  = in_valid && (state_q == FILL);
  assign consume = block_ready && (state_q == FULL);
  assign last    = accept && (idx_q == IDX_W'(NIBBLES - 1));

`ifdef NIBBLE_PACKER_FLUSH_EN
  // An empty block (no slot written and none arriving) is never flushed.
  assign flush_req = flush && (state_q == FILL) && (accept || (idx_q != '0));
`else
  assign flush_req = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= FILL;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            idx_q <= idx_q + 1'b1;
          end
          // Count covers the nibble accepted this cycle, so idx 31 gives 32.
          if (last || flush_req) begin
            state_q <= FULL;
            idx_q   <= '0;
            count_q <= CNT_W'(idx_q) + CNT_W'(accept);
          end
        end
        FULL: begin
          if (block_ready) begin
            state_q <= FILL;
            idx_q   <= '0;
            count_q <= '0;
          end
        end
        default: begin
          state_q <= FILL;
          idx_q   <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

  nibble_write_decoder u_wr_dec (
    .clock  (clock),
    .resetn (resetn),
    .accept (accept),
    .clear  (consume),
    .idx    (idx_q),
    .nibble (in_nibble),
    .block  (block)
  );

  assign in_ready    = (state_q == FILL);
  assign block_valid = (state_q == FULL);
  assign block_count = count_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer; flush cases run when NIBBLE_PACKER_FLUSH_EN
// is defined.
module tb_nibble_packer;
  import a51_pkg::*;

  logic                clock = 1'b0;
  logic                resetn;
  logic [NIBBLE_W-1:0] in_nibble;
  logic                in_valid;
  logic                in_ready;
  logic [BLOCK_W-1:0]  block;
  logic [CNT_W-1:0]    block_count;
  logic                block_valid;
  logic                block_ready;
  logic                fsm_state;
  logic                flush;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BLOCK_W-1:0] exp_q[$];

  always #5 clock = ~clock;

  nibble_packer dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_nibble   (in_nibble),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .block       (block),
    .block_count (block_count),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .fsm_state   (fsm_state)
`ifdef NIBBLE_PACKER_FLUSH_EN
    ,
    .flush       (flush)
`endif
  );

  task automatic check_eq(input string tag, input logic [BLOCK_W-1:0] obs,
                          input logic [BLOCK_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NIBBLE_W-1:0] nib_sel(input logic [BLOCK_W-1:0] b, input int idx);
    return b[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

  function automatic logic [BLOCK_W-1:0] pack_block(input logic [3:0] nibs [NIBBLES]);
    logic [BLOCK_W-1:0] b = '0;
    for (int k = 0; k < NIBBLES; k++) b[k*NIBBLE_W +: NIBBLE_W] = nibs[k];
    return b;
  endfunction

  // Called at a negedge; returns at the negedge after the nibble was taken.
  task automatic send_nibble(input logic [3:0] n);
    int guard = 0;
    in_nibble = n;
    in_valid  = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) check_eq("send_timeout", in_ready, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [3:0] nibs [NIBBLES], input bit gaps);
    exp_q.push_back(pack_block(nibs));
    for (int k = 0; k < NIBBLES; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) @(negedge clock);
      send_nibble(nibs[k]);
    end
  endtask

  task automatic take_block(input string tag, input logic [CNT_W-1:0] exp_cnt,
                            output logic [BLOCK_W-1:0] got);
    int guard = 0;
    logic [BLOCK_W-1:0] exp = '0;
    while (!block_valid && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) check_eq({tag, "_timeout"}, block_valid, 1'b1);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    got = block;
    check_eq({tag, "_block"}, block, exp);
    check_eq({tag, "_count"}, block_count, exp_cnt);
    block_ready = 1'b1;
    @(negedge clock);
    block_ready = 1'b0;
    check_eq({tag, "_released"}, block_valid, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_block"}, block, '0);
    check_eq({tag, "_count"}, block_count, '0);
    check_eq({tag, "_valid"}, block_valid, 1'b0);
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    check_eq({tag, "_state"}, fsm_state, FILL);
  endtask

  initial begin
    logic [3:0]         nibs [NIBBLES];
    logic [BLOCK_W-1:0] got;
    logic [BLOCK_W-1:0] held;

    resetn      = 1'b0;
    in_nibble   = '0;
    in_valid    = 1'b0;
    block_ready = 1'b0;
    flush       = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("rst_in");
    resetn = 1'b1;
    @(negedge clock);
    check_reset_vals("rst_out");

    // 1: 0..F,0..F back-to-back with block_ready high throughout
    block_ready = 1'b1;
    for (int i = 0; i < NIBBLES; i++) begin
      send_nibble(4'(i));
      if (i == NIBBLES - 2) check_eq("t1_not_yet_valid", block_valid, 1'b0);
    end
    check_eq("t1_valid", block_valid, 1'b1);
    check_eq("t1_block", block, 128'hFEDCBA9876543210FEDCBA9876543210);
    check_eq("t1_count", block_count, 6'd32);
    check_eq("t1_in_ready", in_ready, 1'b0);
    @(negedge clock);
    block_ready = 1'b0;
    check_reset_vals("t1_after_consume");

    // 2: hold a full block for 10 cycles with in_valid pending
    for (int k = 0; k < NIBBLES; k++) nibs[k] = 4'((k * 3 + 1) & 15);
    send_block(nibs, 1'b0);
    held      = pack_block(nibs);
    in_nibble = 4'h5;
    in_valid  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check_eq("t2_hold_in_ready", in_ready, 1'b0);
      check_eq("t2_hold_block", block, held);
      @(negedge clock);
    end
    take_block("t2", 6'd32, got);
    check_eq("t2_consume_no_accept", block, '0);
    check_eq("t2_in_ready_back", in_ready, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    check_eq("t2_first_nibble", block, 128'h5);
    nibs[0] = 4'h5;
    for (int k = 1; k < NIBBLES; k++) nibs[k] = 4'((15 - k) & 15);
    exp_q.push_back(pack_block(nibs));
    for (int k = 1; k < NIBBLES; k++) send_nibble(nibs[k]);
    take_block("t2b", 6'd32, got);

    // 3+4: random gaps over 4 blocks, read back through the nibble mux
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < NIBBLES; k++) nibs[k] = 4'($urandom_range(0, 15));
      send_block(nibs, 1'b1);
      take_block("t3", 6'd32, got);
      for (int k = 0; k < NIBBLES; k++) check_eq("t4_readback", nib_sel(got, k), nibs[k]);
    end

    // 5: reset after 17 nibbles discards the partial block
    for (int k = 0; k < 17; k++) send_nibble(4'hC);
    resetn = 1'b0;
    #1;
    check_reset_vals("t5_rst");
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check_reset_vals("t5_rst_rel");
    for (int k = 0; k < NIBBLES; k++) nibs[k] = 4'((k + 2) & 15);
    send_block(nibs, 1'b0);
    take_block("t5", 6'd32, got);

`ifdef NIBBLE_PACKER_FLUSH_EN
    // 6: flush partial blocks
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check_eq("t6_empty_flush_ignored", block_valid, 1'b0);
    for (int k = 0; k < 5; k++) send_nibble(4'hA);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    exp_q.push_back(128'hAAAAA);
    take_block("t6_flush5", 6'd5, got);
    for (int k = 0; k < 5; k++) send_nibble(4'hA);
    in_nibble = 4'hB;
    in_valid  = 1'b1;
    flush     = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    flush    = 1'b0;
    exp_q.push_back(128'hBAAAAA);
    take_block("t6_flush6", 6'd6, got);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
